dpe_tx_retry: RTL
=================

# dpe_tx_retry

Protocol-layer transmit controller for the USB PD policy engine. Accepts a send request from the policy engine, starts the PHY transmission with the current MessageID, and drives start/stop of the external CRCReceiveTimer. It consumes that timer's timeout, retries on timeout or PHY error, and reports success or failure. It sits between the policy engine, the PHY TX/RX paths, and the CRCReceiveTimer instance in the parent, which is a start/stop/timeout counter.

## Interface
- RETRY_MAX, 3, retransmissions after the first attempt (nRetryCount); width 2 bits is sufficient.
- MSGID_W, 3, MessageID counter width.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- prl_reset  in  1  protocol soft reset; synchronous, highest priority.
- tx_req  in  1  single-cycle send request from the policy engine.
- tx_busy  out  1  high whenever state is not IDLE.
- tx_done  out  1  one-cycle pulse: matching GoodCRC received.
- tx_fail  out  1  one-cycle pulse: retries exhausted.
- phy_tx_start  out  1  one-cycle pulse to the PHY.
- phy_tx_msg_id  out  MSGID_W  current MessageID; valid while tx_busy.
- phy_tx_end  in  1  pulse: PHY finished sending the frame.
- phy_tx_err  in  1  pulse: PHY discarded or aborted the frame.
- rx_goodcrc  in  1  pulse: a GoodCRC was received.
- rx_goodcrc_id  in  MSGID_W  MessageID carried by that GoodCRC.
- tmr_start  out  1  one-cycle pulse: (re)start CRCReceiveTimer.
- tmr_stop  out  1  one-cycle pulse: clear CRCReceiveTimer.
- tmr_timeout  in  1  level: timer expired; held until the next stop or start.

## Operation
- All outputs are registered. Reset values: every output is 0. Internal reset values: state IDLE, msg_id 0, retry_cnt 0.
- IDLE:
  - On tx_req: clear retry_cnt and go to SEND.
  - tx_req received in any other state is ignored; it is not queued.
- SEND:
  - Assert phy_tx_start for one cycle, then go to WAIT_END.
- WAIT_END:
  - On phy_tx_end: pulse tmr_start and go to WAIT_CRC.
  - On phy_tx_err: go to RETRY.
  - If phy_tx_end and phy_tx_err arrive in the same cycle, the error wins.
- WAIT_CRC:
  - On rx_goodcrc with rx_goodcrc_id == msg_id: pulse tmr_stop and tx_done, increment msg_id modulo 2^MSGID_W, go to IDLE.
  - A GoodCRC with a mismatched ID is ignored; the block stays in WAIT_CRC.
  - On tmr_timeout: pulse tmr_stop and go to RETRY.
  - If a matching GoodCRC and tmr_timeout arrive in the same cycle, the GoodCRC wins.
- RETRY (single cycle):
  - If retry_cnt < RETRY_MAX: increment retry_cnt and go to SEND.
  - Otherwise: pulse tx_fail, increment msg_id, go to IDLE.
- tmr_timeout is sampled only in WAIT_CRC. rx_goodcrc is sampled only in WAIT_CRC. phy_tx_end and phy_tx_err are sampled only in WAIT_END.
- prl_reset, in any state:
  - Next state is IDLE; msg_id and retry_cnt are cleared.
  - tmr_stop pulses if the block was in WAIT_CRC.
  - No tx_done or tx_fail is generated.
  - A tx_req arriving in the same cycle is dropped.
- msg_id wraps from 2^MSGID_W−1 to 0 with no flag.

## Timing
- tx_req sampled at edge N → phy_tx_start high during cycle N+1 → WAIT_END from N+2.
- phy_tx_end at edge M → tmr_start high during M+1.
- The timer expires VALUE cycles later. Its stale timeout is cleared by the next tmr_start, and the block never samples it outside WAIT_CRC.
- Matching GoodCRC at edge K → tx_done and tmr_stop high during K+1 → tx_busy low from K+1.
- Timeout at edge T → RETRY during T+1 → phy_tx_start during T+2, or tx_fail during T+2 if retries are exhausted.
- Worst case: 1 + RETRY_MAX transmissions per request.
- Back-to-back operation: tx_req is accepted in the first cycle tx_busy is low.

## Structure
- The shared package dpe_pkg holds:
  - state enum (IDLE, SEND, WAIT_END, WAIT_CRC, RETRY);
  - MSGID_W;
  - default RETRY_MAX (nRetryCount).
- Single flat module; no sub-module. The CRCReceiveTimer is instantiated in the parent and connected through tmr_*.

## Test plan
- Clean send: tx_req, then phy_tx_end, then GoodCRC with id 0 after 5 cycles → one phy_tx_start with id 0, tmr_start then tmr_stop, tx_done, msg_id becomes 1.
- Timeout retries: no GoodCRC, RETRY_MAX=3 → exactly 4 phy_tx_start pulses, all with the same id. Then one tx_fail, msg_id incremented, tx_busy low.
- Mismatch then match: GoodCRC id 5 while msg_id=2 is ignored; id 2 arrives next → tx_done. Also: GoodCRC together with tmr_timeout in the same cycle → tx_done, no retry.
- PHY error: phy_tx_err on the first attempt → retry_cnt becomes 1 and a second phy_tx_start follows 2 cycles later; that attempt succeeds → tx_done.
- Wrap and reset: 8 successful sends → msg_id returns to 0. prl_reset in WAIT_CRC → tmr_stop, IDLE, msg_id 0, no done or fail. rst_n mid-send → all outputs 0.

Source files
------------

// File: rtl/dpe_pkg.sv
// dpe_pkg: definitions shared by the USB PD protocol-layer blocks.
//   MSGID_W   - width of the MessageID counter.
//   RETRY_MAX - default nRetryCount (retransmissions after the first attempt).
//   state_t   - transmit controller states.
package dpe_pkg;

  localparam int MSGID_W   = 3;
  localparam int RETRY_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_END,
    WAIT_CRC,
    RETRY
  } state_t;

endpackage

// File: rtl/dpe_tx_retry.sv
// dpe_tx_retry: protocol-layer transmit controller with GoodCRC retry.
// Starts a PHY transmission with the current MessageID, arms the external
// CRCReceiveTimer once the frame is out, and retransmits on timeout or PHY
// error until nRetryCount is exhausted.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   prl_reset          synchronous protocol soft reset (highest priority)
//   tx_req             single-cycle send request from the policy engine
//   tx_busy            high while not idle
//   tx_done / tx_fail  one-cycle completion pulses
//   phy_tx_start       one-cycle transmit pulse to the PHY
//   phy_tx_msg_id      MessageID of the frame being sent
//   phy_tx_end/err     PHY frame finished / aborted
//   rx_goodcrc(_id)    GoodCRC received and its MessageID
//   tmr_start/stop     CRCReceiveTimer control pulses
//   tmr_timeout        CRCReceiveTimer expiry level
module dpe_tx_retry #(
  parameter int RETRY_MAX = dpe_pkg::RETRY_MAX,
  parameter int MSGID_W   = dpe_pkg::MSGID_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prl_reset,
  input  logic               tx_req,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               tx_fail,
  output logic               phy_tx_start,
  output logic [MSGID_W-1:0] phy_tx_msg_id,
  input  logic               phy_tx_end,
  input  logic               phy_tx_err,
  input  logic               rx_goodcrc,
  input  logic [MSGID_W-1:0] rx_goodcrc_id,
  output logic               tmr_start,
  output logic               tmr_stop,
  input  logic               tmr_timeout
);
  import dpe_pkg::*;

  localparam int RC_W = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);

  state_t             state_reg, state_next;
  logic [MSGID_W-1:0] msg_id_reg, msg_id_next;
  logic [RC_W-1:0]    retry_reg, retry_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               fail_reg, fail_next;
  logic               start_reg, start_next;
  logic               tmr_start_reg, tmr_start_next;
  logic               tmr_stop_reg, tmr_stop_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      msg_id_reg    <= '0;
      retry_reg     <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      start_reg     <= 1'b0;
      tmr_start_reg <= 1'b0;
      tmr_stop_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      msg_id_reg    <= msg_id_next;
      retry_reg     <= retry_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      fail_reg      <= fail_next;
      start_reg     <= start_next;
      tmr_start_reg <= tmr_start_next;
      tmr_stop_reg  <= tmr_stop_next;
    end
  end

  // Every output pulse is decided on the transition that causes it, so it is
  // registered alongside the state and appears in the cycle after the event.
  always_comb begin
    state_next     = state_reg;
    msg_id_next    = msg_id_reg;
    retry_next     = retry_reg;
    done_next      = 1'b0;
    fail_next      = 1'b0;
    start_next     = 1'b0;
    tmr_start_next = 1'b0;
    tmr_stop_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (tx_req) begin
          retry_next = '0;
          state_next = SEND;
          start_next = 1'b1;
        end
      end
      SEND: begin
        state_next = WAIT_END;
      end
      WAIT_END: begin
        // An aborted frame is retried even if the PHY also reported its end.
        if (phy_tx_err) begin
          state_next = RETRY;
        end else if (phy_tx_end) begin
          tmr_start_next = 1'b1;
          state_next     = WAIT_CRC;
        end
      end
      WAIT_CRC: begin
        // A matching GoodCRC beats a timeout seen in the same cycle.
        if (rx_goodcrc && (rx_goodcrc_id == msg_id_reg)) begin
          tmr_stop_next = 1'b1;
          done_next     = 1'b1;
          msg_id_next   = msg_id_reg + MSGID_W'(1);
          state_next    = IDLE;
        end else if (tmr_timeout) begin
          tmr_stop_next = 1'b1;
          state_next    = RETRY;
        end
      end
      RETRY: begin
        if (retry_reg < RC_W'(RETRY_MAX)) begin
          retry_next = retry_reg + RC_W'(1);
          start_next = 1'b1;
          state_next = SEND;
        end else begin
          fail_next   = 1'b1;
          msg_id_next = msg_id_reg + MSGID_W'(1);
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Soft reset drops any pending work; only a running timer is stopped.
    if (prl_reset) begin
      state_next     = IDLE;
      msg_id_next    = '0;
      retry_next     = '0;
      done_next      = 1'b0;
      fail_next      = 1'b0;
      start_next     = 1'b0;
      tmr_start_next = 1'b0;
      tmr_stop_next  = (state_reg == WAIT_CRC);
    end
  end

  assign busy_next = (state_next != IDLE);

  assign tx_busy       = busy_reg;
  assign tx_done       = done_reg;
  assign tx_fail       = fail_reg;
  assign phy_tx_start  = start_reg;
  assign phy_tx_msg_id = msg_id_reg;
  assign tmr_start     = tmr_start_reg;
  assign tmr_stop      = tmr_stop_reg;

endmodule
